// File: rtl/debounced_input_pio.sv
// Avalon-MM input PIO: per-bit two-flop synchronizer, counter debounce, sticky edge
// capture with write-1-to-clear, and a maskable registered level interrupt.
module debounced_input_pio #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_MODE       = 2,
    parameter logic [WIDTH-1:0] INIT_VALUE      = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic             ins_irq,
    input  logic [WIDTH-1:0] pin_in
);

    localparam int unsigned      CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_RAW  = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] rise, fall, capture, clr, wr_bits;
    logic             irq_d;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    assign wr_bits      = avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;

    // Any cycle where sync2 agrees with stable restarts the count.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable_d & ~stable_q;
    assign fall = stable_q & ~stable_d;

    always_comb begin
        if (EDGE_MODE == 0) begin
            capture = rise;
        end else if (EDGE_MODE == 1) begin
            capture = fall;
        end else begin
            capture = rise | fall;
        end
    end

    // A capture landing in the same cycle as its clear wins.
    assign clr    = (avs_write && avs_address == ADDR_EDGE) ? wr_bits : '0;
    assign edge_d = (edge_q & ~clr) | capture;
    assign mask_d = (avs_write && avs_address == ADDR_MASK) ? wr_bits : mask_q;
    assign irq_d  = |(edge_d & mask_d);

    always_comb begin
        rd_word = '0;
        unique case (avs_address)
            ADDR_DATA: rd_word[WIDTH-1:0] = stable_q;
            ADDR_MASK: rd_word[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_word[WIDTH-1:0] = edge_q;
            ADDR_RAW:  rd_word[WIDTH-1:0] = sync2_q;
            default:   rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= INIT_VALUE;
            sync2_q      <= INIT_VALUE;
            stable_q     <= INIT_VALUE;
            mask_q       <= '0;
            edge_q       <= '0;
            ins_irq      <= 1'b0;
            avs_readdata <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= pin_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            ins_irq  <= irq_d;
            if (avs_read) begin
                avs_readdata <= rd_word;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_debounced_input_pio.sv
// Directed bench for debounced_input_pio: one DUT capturing both edges, one rising-only,
// sharing clock, reset and the bus strobes but with separate pins and outputs.
module tb_debounced_input_pio;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [3:0]  pin_a = '0;
    logic [3:0]  pin_b = '0;
    logic [31:0] readdata_a, readdata_b;
    logic        irq_a, irq_b;
    logic [31:0] da, db;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    debounced_input_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .INIT_VALUE(4'b0000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_readdata(readdata_a), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .ins_irq(irq_a), .pin_in(pin_a)
    );

    debounced_input_pio #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .INIT_VALUE(4'b0000)
    ) dut_rise (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
        .avs_readdata(readdata_b), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .ins_irq(irq_b), .pin_in(pin_b)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] ra,
                            output logic [31:0] rb);
        avs_address = addr;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        ra          = readdata_a;
        rb          = readdata_b;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (irq_a !== 1'b0) begin
            errors++; $display("FAIL reset_irq: got %b expected 0", irq_a);
        end
        checks++;
        if (readdata_a !== 32'h0) begin
            errors++; $display("FAIL reset_readdata: got %h expected 0", readdata_a);
        end
        reset_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), da, db);
            checks++;
            if (da !== 32'h0) begin
                errors++; $display("FAIL reset_read_addr%0d: got %h expected 0", a, da);
            end
        end
    endtask

    task automatic test_clean_press();
        bus_write(2'd1, 32'h1);
        bus_read(2'd1, da, db);
        checks++;
        if (da !== 32'h1) begin
            errors++; $display("FAIL press_mask_rb: got %h expected 1", da);
        end
        pin_a = 4'b0001;
        repeat (5) tick();
        checks++;
        if (irq_a !== 1'b0) begin
            errors++; $display("FAIL press_irq_edge5: got %b expected 0", irq_a);
        end
        tick();
        checks++;
        if (irq_a !== 1'b1) begin
            errors++; $display("FAIL press_irq_edge6: got %b expected 1", irq_a);
        end
        bus_read(2'd0, da, db);
        checks++;
        if (da !== 32'h1) begin
            errors++; $display("FAIL press_data: got %h expected 1", da);
        end
        bus_read(2'd2, da, db);
        checks++;
        if (da !== 32'h1) begin
            errors++; $display("FAIL press_edge: got %h expected 1", da);
        end
        bus_write(2'd2, 32'h1);
        checks++;
        if (irq_a !== 1'b0) begin
            errors++; $display("FAIL press_clear_irq: got %b expected 0", irq_a);
        end
        pin_a = 4'b0000;
        repeat (10) tick();
        bus_read(2'd2, da, db);
        checks++;
        if (da !== 32'h1) begin
            errors++; $display("FAIL release_edge: got %h expected 1", da);
        end
        checks++;
        if (irq_a !== 1'b1) begin
            errors++; $display("FAIL release_irq: got %b expected 1", irq_a);
        end
        bus_write(2'd2, 32'hFFFF_FFFF);
    endtask

    task automatic test_glitch();
        logic [31:0] exp;
        bus_write(2'd1, 32'h3);
        avs_address = 2'd3;
        avs_read    = 1'b1;
        pin_a       = 4'b0010;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 3) pin_a = 4'b0000;
            exp = (k >= 3 && k <= 5) ? 32'h2 : 32'h0;
            checks++;
            if (readdata_a !== exp) begin
                errors++; $display("FAIL glitch_raw_k%0d: got %h expected %h", k, readdata_a, exp);
            end
            checks++;
            if (irq_a !== 1'b0) begin
                errors++; $display("FAIL glitch_irq_k%0d: got %b expected 0", k, irq_a);
            end
        end
        avs_read = 1'b0;
        repeat (4) tick();
        bus_read(2'd0, da, db);
        checks++;
        if (da !== 32'h0) begin
            errors++; $display("FAIL glitch_data: got %h expected 0", da);
        end
        bus_read(2'd2, da, db);
        checks++;
        if (da !== 32'h0) begin
            errors++; $display("FAIL glitch_edge: got %h expected 0", da);
        end
    endtask

    task automatic test_w1c_race();
        bus_write(2'd1, 32'h1);
        pin_a = 4'b0011;
        repeat (8) tick();
        bus_read(2'd2, da, db);
        checks++;
        if (da !== 32'h3) begin
            errors++; $display("FAIL race_setup_edge: got %h expected 3", da);
        end
        pin_a = 4'b0010;
        repeat (5) tick();
        bus_write(2'd2, 32'h3);
        checks++;
        if (irq_a !== 1'b1) begin
            errors++; $display("FAIL race_irq: got %b expected 1", irq_a);
        end
        bus_read(2'd2, da, db);
        checks++;
        if (da !== 32'h1) begin
            errors++; $display("FAIL race_edge: got %h expected 1", da);
        end
        bus_read(2'd0, da, db);
        checks++;
        if (da !== 32'h2) begin
            errors++; $display("FAIL race_data: got %h expected 2", da);
        end
    endtask

    task automatic test_back_to_back();
        avs_address   = 2'd1;
        avs_writedata = 32'h5;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        tick();
        avs_read  = 1'b0;
        avs_write = 1'b0;
        checks++;
        if (readdata_a !== 32'h1) begin
            errors++; $display("FAIL rw_same_cycle: got %h expected 1", readdata_a);
        end
        tick();
        checks++;
        if (readdata_a !== 32'h1) begin
            errors++; $display("FAIL readdata_hold: got %h expected 1", readdata_a);
        end
        bus_read(2'd1, da, db);
        checks++;
        if (da !== 32'h5) begin
            errors++; $display("FAIL rw_mask_after: got %h expected 5", da);
        end
        bus_write(2'd0, 32'hF);
        bus_read(2'd0, da, db);
        checks++;
        if (da !== 32'h2) begin
            errors++; $display("FAIL data_write_ignored: got %h expected 2", da);
        end
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, da, db);
        checks++;
        if (da !== 32'hF) begin
            errors++; $display("FAIL mask_upper_bits: got %h expected f", da);
        end
        bus_write(2'd1, 32'h0);
        checks++;
        if (irq_a !== 1'b0) begin
            errors++; $display("FAIL mask_off_irq: got %b expected 0", irq_a);
        end
        bus_write(2'd2, 32'hFFFF_FFFF);
    endtask

    task automatic test_rise_only();
        bus_write(2'd1, 32'h4);
        pin_b = 4'b0100;
        repeat (10) tick();
        checks++;
        if (irq_b !== 1'b1) begin
            errors++; $display("FAIL rise_irq: got %b expected 1", irq_b);
        end
        bus_read(2'd2, da, db);
        checks++;
        if (db !== 32'h4) begin
            errors++; $display("FAIL rise_edge: got %h expected 4", db);
        end
        bus_write(2'd2, 32'h4);
        checks++;
        if (irq_b !== 1'b0) begin
            errors++; $display("FAIL rise_clear_irq: got %b expected 0", irq_b);
        end
        pin_b = 4'b0000;
        repeat (10) tick();
        bus_read(2'd2, da, db);
        checks++;
        if (db !== 32'h0) begin
            errors++; $display("FAIL fall_not_captured: got %h expected 0", db);
        end
        checks++;
        if (irq_b !== 1'b0) begin
            errors++; $display("FAIL fall_irq: got %b expected 0", irq_b);
        end
        bus_read(2'd0, da, db);
        checks++;
        if (db !== 32'h0) begin
            errors++; $display("FAIL rise_only_data: got %h expected 0", db);
        end
    endtask

    task automatic test_reset_mid_debounce();
        pin_a = 4'b0000;
        repeat (10) tick();
        bus_write(2'd2, 32'hFFFF_FFFF);
        pin_a = 4'b0001;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (readdata_a !== 32'h0) begin
            errors++; $display("FAIL midreset_readdata: got %h expected 0", readdata_a);
        end
        checks++;
        if (irq_a !== 1'b0) begin
            errors++; $display("FAIL midreset_irq: got %b expected 0", irq_a);
        end
        tick();
        tick();
        reset_n = 1'b1;
        bus_write(2'd1, 32'h1);
        repeat (4) tick();
        checks++;
        if (irq_a !== 1'b0) begin
            errors++; $display("FAIL midreset_irq_edge5: got %b expected 0", irq_a);
        end
        tick();
        checks++;
        if (irq_a !== 1'b1) begin
            errors++; $display("FAIL midreset_irq_edge6: got %b expected 1", irq_a);
        end
        bus_read(2'd2, da, db);
        checks++;
        if (da !== 32'h1) begin
            errors++; $display("FAIL midreset_edge: got %h expected 1", da);
        end
        bus_read(2'd0, da, db);
        checks++;
        if (da !== 32'h1) begin
            errors++; $display("FAIL midreset_data: got %h expected 1", da);
        end
        bus_write(2'd2, 32'h1);
        repeat (10) tick();
        bus_read(2'd2, da, db);
        checks++;
        if (da !== 32'h0) begin
            errors++; $display("FAIL midreset_single_edge: got %h expected 0", da);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_w1c_race();
        test_back_to_back();
        test_rise_only();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
